hdu_p: RTL and testbench

Parametrised hazard detection and forwarding unit for the in-order 5-stage pipeline. It generates EX-stage operand forwarding selects and load-use stalls that last a configurable number of cycles, held by a small state machine. It also drives branch-redirect flushes and keeps a saturating stall-cycle performance counter. It sits between the ID/EX, EX/MEM and MEM/WB pipeline registers and the IF/ID hold and flush controls.

---
 rtl/hdu_p.sv | 140 ++++++++++++++
 tb/tb_hdu_p.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hdu_p.sv
// Hazard detection and forwarding unit for the 5-stage in-order pipeline:
// EX operand forwarding, multi-cycle load-use stalls, branch flushes, stall counter.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | no stall pending; a load-use hit stalls in the detection cycle
//  STALL | remaining rem cycles of a load-use stall; ID/EX holds a bubble

module hdu_p #(
   parameter int AW       = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    id_rs1,
   input  logic [AW-1:0]    id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [AW-1:0]    idex_rs1,
   input  logic [AW-1:0]    idex_rs2,
   input  logic [AW-1:0]    idex_rd,
   input  logic             idex_memRead,
   input  logic [AW-1:0]    exmem_rd,
   input  logic [AW-1:0]    memwb_rd,
   input  logic             exmem_regWrite,
   input  logic             memwb_regWrite,
   input  logic             ex_branch_taken,
   input  logic             perf_clr,
   output logic [1:0]       forwA,
   output logic [1:0]       forwB,
   output logic             stall,
   output logic             bubble_idex,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } state_t;

   localparam logic [1:0]       FWD_RF   = 2'b00;
   localparam logic [1:0]       FWD_EXM  = 2'b01;
   localparam logic [1:0]       FWD_MWB  = 2'b10;
   localparam logic [2:0]       REM_INIT = 3'(LOAD_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state_q, state_d;
   logic [2:0]       rem_q, rem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic exm_a, exm_b, mwb_a, mwb_b;
   logic hit;
   logic stall_int;

   // Forwarding: EX/MEM holds the younger result, so it takes priority.
   always_comb begin
      exm_a = exmem_regWrite && (exmem_rd != '0) && (exmem_rd == idex_rs1);
      exm_b = exmem_regWrite && (exmem_rd != '0) && (exmem_rd == idex_rs2);
      mwb_a = memwb_regWrite && (memwb_rd != '0) && (memwb_rd == idex_rs1);
      mwb_b = memwb_regWrite && (memwb_rd != '0) && (memwb_rd == idex_rs2);

      forwA = FWD_RF;
      if (exm_a)      forwA = FWD_EXM;
      else if (mwb_a) forwA = FWD_MWB;

      forwB = FWD_RF;
      if (exm_b)      forwB = FWD_EXM;
      else if (mwb_b) forwB = FWD_MWB;
   end

   always_comb begin
      hit = idex_memRead && (idex_rd != '0) &&
            ((id_use_rs1 && (idex_rd == id_rs1)) ||
             (id_use_rs2 && (idex_rd == id_rs2)));
   end

   // A taken branch overrides any stall; outputs are held low during reset.
   always_comb begin
      stall_int = 1'b0;
      case (state_q)
         IDLE:    stall_int = hit && !ex_branch_taken;
         STALL:   stall_int = !ex_branch_taken;
         default: stall_int = 1'b0;
      endcase
      stall       = rst_n && stall_int;
      bubble_idex = stall;
      flush_ifid  = rst_n && ex_branch_taken;
      flush_idex  = rst_n && ex_branch_taken;
      stall_cnt   = cnt_q;
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE: begin
            if (stall_int && (LOAD_LAT > 1)) begin
               state_d = STALL;
               rem_d   = REM_INIT;
            end
         end
         STALL: begin
            if (ex_branch_taken || (rem_q == 3'd1)) begin
               state_d = IDLE;
               rem_d   = 3'd0;
            end else begin
               rem_d   = rem_q - 3'd1;
            end
         end
         default: begin
            state_d = IDLE;
            rem_d   = 3'd0;
         end
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (perf_clr)
         cnt_d = '0;
      else if (stall_int && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rem_q   <= 3'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hdu_p.sv
// Scoreboard bench for hdu_p: two instances (LOAD_LAT=3/CNT_W=16 and
// LOAD_LAT=4/CNT_W=4) share stimulus; a monitor pops expected values and compares.

module tb_hdu_p;

   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
   logic          id_use_rs1, id_use_rs2, idex_memRead;
   logic          exmem_regWrite, memwb_regWrite, ex_branch_taken, perf_clr;

   logic [1:0]  forwA3, forwB3, forwA4, forwB4;
   logic        stall3, bubble3, fifid3, fidex3;
   logic        stall4, bubble4, fifid4, fidex4;
   logic [15:0] cnt3;
   logic [3:0]  cnt4;

   always #5 clk = ~clk;

   hdu_p #(.AW(AW), .LOAD_LAT(3), .CNT_W(16)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_memRead(idex_memRead),
      .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
      .exmem_regWrite(exmem_regWrite), .memwb_regWrite(memwb_regWrite),
      .ex_branch_taken(ex_branch_taken), .perf_clr(perf_clr),
      .forwA(forwA3), .forwB(forwB3), .stall(stall3), .bubble_idex(bubble3),
      .flush_ifid(fifid3), .flush_idex(fidex3), .stall_cnt(cnt3)
   );

   hdu_p #(.AW(AW), .LOAD_LAT(4), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_memRead(idex_memRead),
      .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
      .exmem_regWrite(exmem_regWrite), .memwb_regWrite(memwb_regWrite),
      .ex_branch_taken(ex_branch_taken), .perf_clr(perf_clr),
      .forwA(forwA4), .forwB(forwB4), .stall(stall4), .bubble_idex(bubble4),
      .flush_ifid(fifid4), .flush_idex(fidex4), .stall_cnt(cnt4)
   );

   typedef enum int {
      S_FWA, S_FWB, S_STALL3, S_BUB3, S_FIFID3, S_FIDEX3, S_CNT3, S_STALL4, S_BUB4, S_CNT4
   } sel_t;

   typedef struct {
      sel_t  sel;
      int    exp;
      string name;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;
   event chk_ev;

   function automatic int actual(sel_t s);
      case (s)
         S_FWA:    return int'(forwA3);
         S_FWB:    return int'(forwB3);
         S_STALL3: return int'(stall3);
         S_BUB3:   return int'(bubble3);
         S_FIFID3: return int'(fifid3);
         S_FIDEX3: return int'(fidex3);
         S_CNT3:   return int'(cnt3);
         S_STALL4: return int'(stall4);
         S_BUB4:   return int'(bubble4);
         S_CNT4:   return int'(cnt4);
         default:  return -1;
      endcase
   endfunction

   task automatic expect_v(sel_t s, int v, string n);
      exp_t e;
      e.sel = s; e.exp = v; e.name = n;
      sbq.push_back(e);
   endtask

   // Monitor: compares all queued expectations when outputs are sampled.
   initial begin
      forever begin
         @(negedge clk or chk_ev);
         while (sbq.size() > 0) begin
            exp_t e;
            int   a;
            e = sbq.pop_front();
            a = actual(e.sel);
            checks++;
            if (a !== e.exp) begin
               errors++;
               $display("FAIL %s: got %0d expected %0d at %0t", e.name, a, e.exp, $time);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      id_rs1 = '0; id_rs2 = '0; idex_rs1 = '0; idex_rs2 = '0; idex_rd = '0;
      exmem_rd = '0; memwb_rd = '0;
      id_use_rs1 = 0; id_use_rs2 = 0; idex_memRead = 0;
      exmem_regWrite = 0; memwb_regWrite = 0; ex_branch_taken = 0; perf_clr = 0;
   endtask

   task automatic set_hit();
      idex_memRead = 1; idex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1;
   endtask

   initial begin
      rst_n = 1'b0;
      clr_in();
      #1;
      set_hit();
      ex_branch_taken = 1;
      expect_v(S_STALL3, 0, "rst_stall3");
      expect_v(S_STALL4, 0, "rst_stall4");
      expect_v(S_FIFID3, 0, "rst_flush_ifid");
      expect_v(S_FIDEX3, 0, "rst_flush_idex");
      expect_v(S_CNT3, 0, "rst_cnt3");
      expect_v(S_CNT4, 0, "rst_cnt4");

      cyc(); rst_n = 1'b1; clr_in();

      // Forwarding priority
      idex_rs1 = 5'd5; exmem_rd = 5'd5; memwb_rd = 5'd5;
      exmem_regWrite = 1; memwb_regWrite = 1; idex_rs2 = 5'd3;
      expect_v(S_FWA, 1, "fwd_both_exmem");
      expect_v(S_FWB, 0, "fwd_b_none");
      cyc(); exmem_regWrite = 0;
      expect_v(S_FWA, 2, "fwd_memwb");
      cyc(); exmem_rd = 0; memwb_rd = 0; idex_rs1 = 0; exmem_regWrite = 1;
      expect_v(S_FWA, 0, "fwd_x0");
      cyc(); idex_rs2 = 5'd9; exmem_rd = 5'd9; memwb_rd = 5'd9;
      expect_v(S_FWB, 1, "fwd_b_exmem");
      expect_v(S_FWA, 0, "fwd_a_none");
      cyc(); clr_in();

      // Load-use: dut3 stalls 3 cycles, dut4 stalls 4
      set_hit();
      expect_v(S_STALL3, 1, "lu_c0_stall3");
      expect_v(S_BUB3, 1, "lu_c0_bubble3");
      expect_v(S_STALL4, 1, "lu_c0_stall4");
      expect_v(S_CNT3, 0, "lu_c0_cnt3");
      cyc(); clr_in();
      expect_v(S_STALL3, 1, "lu_c1_stall3");
      expect_v(S_BUB3, 1, "lu_c1_bubble3");
      expect_v(S_CNT3, 1, "lu_c1_cnt3");
      cyc();
      expect_v(S_STALL3, 1, "lu_c2_stall3");
      expect_v(S_CNT3, 2, "lu_c2_cnt3");
      cyc();
      expect_v(S_STALL3, 0, "lu_c3_stall3");
      expect_v(S_BUB3, 0, "lu_c3_bubble3");
      expect_v(S_CNT3, 3, "lu_c3_cnt3");
      expect_v(S_STALL4, 1, "lu_c3_stall4");
      cyc();
      expect_v(S_STALL4, 0, "lu_c4_stall4");
      expect_v(S_CNT4, 4, "lu_c4_cnt4");
      expect_v(S_CNT3, 3, "lu_c4_cnt3");

      // No false stall
      cyc(); idex_memRead = 1; idex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
      expect_v(S_STALL3, 0, "nf_x0_stall");
      cyc(); clr_in(); idex_memRead = 1; idex_rd = 5'd5; id_rs2 = 5'd5;
      expect_v(S_STALL3, 0, "nf_unused_stall");
      cyc(); clr_in();
      expect_v(S_CNT3, 3, "nf_cnt3");
      expect_v(S_STALL3, 0, "nf_after_stall");

      // Branch beats hit
      cyc(); set_hit(); ex_branch_taken = 1;
      expect_v(S_STALL3, 0, "br_hit_stall");
      expect_v(S_BUB3, 0, "br_hit_bubble");
      expect_v(S_FIFID3, 1, "br_flush_ifid");
      expect_v(S_FIDEX3, 1, "br_flush_idex");
      cyc(); clr_in();
      expect_v(S_STALL3, 0, "br_idle_stall3");
      expect_v(S_STALL4, 0, "br_idle_stall4");
      expect_v(S_FIFID3, 0, "br_noflush");
      expect_v(S_CNT3, 3, "br_cnt3");

      // Branch while in STALL aborts the sequence
      cyc(); set_hit();
      expect_v(S_STALL3, 1, "bs_c0_stall3");
      cyc(); clr_in(); ex_branch_taken = 1;
      expect_v(S_STALL3, 0, "bs_c1_stall3");
      expect_v(S_STALL4, 0, "bs_c1_stall4");
      expect_v(S_FIDEX3, 1, "bs_c1_flush");
      cyc(); clr_in();
      expect_v(S_STALL3, 0, "bs_c2_stall3");
      expect_v(S_STALL4, 0, "bs_c2_stall4");
      expect_v(S_CNT3, 4, "bs_cnt3");
      expect_v(S_CNT4, 5, "bs_cnt4");

      // Reset mid-stall on dut4
      cyc(); set_hit();
      expect_v(S_STALL4, 1, "rs_c0_stall4");
      cyc(); clr_in();
      expect_v(S_STALL4, 1, "rs_c1_stall4");
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      expect_v(S_STALL4, 0, "rs_low_stall4");
      expect_v(S_CNT4, 0, "rs_low_cnt4_async");
      expect_v(S_CNT3, 0, "rs_low_cnt3_async");
      -> chk_ev;
      cyc(); rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expect_v(S_STALL4, 0, "rs_after_stall4");
         expect_v(S_CNT4, 0, "rs_after_cnt4");
         cyc();
      end

      // Saturation and clear: hit held continuously keeps both DUTs stalling
      set_hit();
      for (int i = 0; i < 20; i++) begin
         expect_v(S_STALL4, 1, "sat_stall4");
         cyc();
      end
      perf_clr = 1;
      expect_v(S_CNT4, 15, "sat_cnt4");
      expect_v(S_CNT3, 20, "sat_cnt3");
      expect_v(S_STALL4, 1, "clr_stall4");
      cyc(); perf_clr = 0;
      expect_v(S_CNT4, 0, "clr_cnt4");
      expect_v(S_CNT3, 0, "clr_cnt3");
      cyc(); clr_in();
      expect_v(S_CNT4, 1, "post_clr_cnt4");
      expect_v(S_CNT3, 1, "post_clr_cnt3");

      repeat (6) @(negedge clk);
      #1;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
